// File: rtl/cache_wb_buffer_pkg.sv
// Shared types and constants for the cache write-back buffer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cache_pkg;

    localparam int CW_ADDR_W = 32;
    localparam int CW_WORD_W = 32;
    localparam int CW_WPL    = 4;
    localparam int CW_DEPTH  = 4;
    localparam int CW_LINE_W = CW_WPL * CW_WORD_W;
    // byte-offset bits inside one line, and shift from beat index to byte offset
    localparam int CW_OFF_W  = $clog2(CW_LINE_W / 8);
    localparam int CW_BSH    = $clog2(CW_WORD_W / 8);
    localparam int CW_BEAT_W = $clog2(CW_WPL);
    localparam int CW_PTR_W  = $clog2(CW_DEPTH);
    localparam int CW_CNT_W  = CW_PTR_W + 1;

    typedef struct packed {
        logic                 valid;
        logic [CW_ADDR_W-1:0] addr;
        logic [CW_LINE_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        WB_IDLE  = 1'b0,
        WB_ISSUE = 1'b1
    } wb_state_e;

    // Clear the in-line byte offset so lines compare by line address only.
    function automatic logic [CW_ADDR_W-1:0] line_base(input logic [CW_ADDR_W-1:0] a);
        line_base = a & {{(CW_ADDR_W - CW_OFF_W){1'b1}}, {CW_OFF_W{1'b0}}};
    endfunction

    // Byte address of a beat within a line; wraps modulo 2^ADDR_W.
    function automatic logic [CW_ADDR_W-1:0] beat_addr(input logic [CW_ADDR_W-1:0] base,
                                                       input logic [CW_BEAT_W-1:0] beat);
        beat_addr = base + (CW_ADDR_W'(beat) << CW_BSH);
    endfunction

endpackage

// File: rtl/cache_wb_buffer_if.sv
// Bundle of cache-side, lookup, memory-side and flush signals of the write-back buffer.
// Latency: n/a (wiring only).
// Backpressure: wb_valid/wb_ready for lines, mem_req/mem_ack for beats.
interface cache_wb_buffer_if #(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4
);
    logic                             wb_valid;
    logic                             wb_ready;
    logic [ADDR_W-1:0]                wb_addr;
    logic [WORDS_PER_LINE*WORD_W-1:0] wb_data;
    logic [ADDR_W-1:0]                lk_addr;
    logic                             lk_hit;
    logic [WORDS_PER_LINE*WORD_W-1:0] lk_data;
    logic                             mem_req;
    logic [ADDR_W-1:0]                mem_addr;
    logic [WORD_W-1:0]                mem_wdata;
    logic                             mem_ack;
    logic                             fl_req;
    logic                             fl_complete;

    // buffer side
    modport slave (
        input  wb_valid, wb_addr, wb_data, lk_addr, mem_ack, fl_req,
        output wb_ready, lk_hit, lk_data, mem_req, mem_addr, mem_wdata, fl_complete
    );

    // cache / memory side
    modport master (
        output wb_valid, wb_addr, wb_data, lk_addr, mem_ack, fl_req,
        input  wb_ready, lk_hit, lk_data, mem_req, mem_addr, mem_wdata, fl_complete
    );
endinterface

// File: rtl/cache_wb_buffer_fifo.sv
// Circular store of pending evicted lines; every slot is exposed for lookup.
// Latency: a push is visible on o_entries the cycle after the write edge.
// Backpressure: o_full is derived from the registered count only; caller must not push when full.
module cache_wb_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = CW_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [CW_ADDR_W-1:0]       i_addr,
    input  logic [CW_LINE_W-1:0]       i_data,
    input  logic                       i_pop,
    output wb_entry_t                  o_entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Slot storage: pop invalidates the head, push writes a fresh valid entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_pop)  r_mem[r_rd_ptr].valid <= 1'b0;
            if (i_push) r_mem[r_wr_ptr] <= '{valid: 1'b1, addr: i_addr, data: i_data};
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_entries = r_mem;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/cache_wb_buffer.sv
// Write-back buffer: queues evicted lines, drains them word-serially, answers read-miss lookups, flush handshake.
// Latency: push into an empty idle buffer -> first beat next cycle; one idle cycle between lines.
// Backpressure: wb_ready low when full (no same-cycle pop bypass); beats held until mem_ack.
module cache_wb_buffer
    import cache_pkg::*;
#(
    parameter int ADDR_W         = CW_ADDR_W,
    parameter int WORD_W         = CW_WORD_W,
    parameter int WORDS_PER_LINE = CW_WPL,
    parameter int DEPTH          = CW_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    cache_wb_buffer_if.slave  bus
);
    // Entry fields are sized by cache_pkg; keep these defaults in step with it.
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                BEAT_W    = $clog2(WORDS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    wb_entry_t         w_entries [DEPTH];
    logic [PTR_W-1:0]  w_rd_ptr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_wb_line;
    logic [ADDR_W-1:0] w_lk_line;
    logic [ADDR_W-1:0] w_head_line;
    logic [BEAT_W-1:0] w_next_beat;
    logic [WORD_W-1:0] w_next_word;
    logic              w_lk_hit;
    logic [CW_LINE_W-1:0] w_lk_data;
    logic [PTR_W-1:0]  w_idx;

    wb_state_e         r_state;
    logic [BEAT_W-1:0] r_beat;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic              r_fl_complete;

    assign w_push      = bus.wb_valid && !w_full;
    assign w_pop       = (r_state == WB_ISSUE) && bus.mem_ack && (r_beat == LAST_BEAT);
    assign w_wb_line   = line_base(bus.wb_addr);
    assign w_lk_line   = line_base(bus.lk_addr);
    assign w_head_line = w_entries[w_rd_ptr].addr;
    assign w_next_beat = r_beat + BEAT_W'(1);
    assign w_next_word = w_entries[w_rd_ptr].data[int'(w_next_beat)*WORD_W +: WORD_W];

    cache_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_addr    (w_wb_line),
        .i_data    (bus.wb_data),
        .i_pop     (w_pop),
        .o_entries (w_entries),
        .o_rd_ptr  (w_rd_ptr),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Drain FSM: load beat 0 from the head (or straight from the incoming line when
    // empty, so the first beat appears the cycle after the push), step on each ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= WB_IDLE;
            r_beat      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                WB_IDLE: begin
                    if (!w_empty) begin
                        r_state     <= WB_ISSUE;
                        r_beat      <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_head_line;
                        r_mem_wdata <= w_entries[w_rd_ptr].data[WORD_W-1:0];
                    end else if (w_push) begin
                        r_state     <= WB_ISSUE;
                        r_beat      <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_wb_line;
                        r_mem_wdata <= bus.wb_data[WORD_W-1:0];
                    end
                end
                WB_ISSUE: begin
                    if (bus.mem_ack) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state   <= WB_IDLE;
                            r_beat    <= '0;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_beat      <= w_next_beat;
                            r_mem_addr  <= beat_addr(w_head_line, w_next_beat);
                            r_mem_wdata <= w_next_word;
                        end
                    end
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

    // Lookup: walk oldest to newest from the read pointer so the newest match wins.
    always_comb begin
        w_lk_hit  = 1'b0;
        w_lk_data = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = w_rd_ptr + PTR_W'(i);
            if (w_entries[w_idx].valid && (w_entries[w_idx].addr == w_lk_line)) begin
                w_lk_hit  = 1'b1;
                w_lk_data = w_entries[w_idx].data;
            end
        end
    end

    // Flush completes once nothing is queued, in flight, or being offered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fl_complete <= 1'b0;
        else      r_fl_complete <= bus.fl_req && w_empty && (r_state == WB_IDLE) && !bus.wb_valid;
    end

    assign bus.wb_ready    = !w_full;
    assign bus.lk_hit      = w_lk_hit;
    assign bus.lk_data     = w_lk_data;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.fl_complete = r_fl_complete;

endmodule

// File: tb/tb_cache_wb_buffer.sv
module tb_cache_wb_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cache_wb_buffer_if u_if ();

    cache_wb_buffer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        u_if.wb_valid = 1'b0; u_if.wb_addr = '0; u_if.wb_data = '0;
        u_if.lk_addr = '0; u_if.mem_ack = 1'b0; u_if.fl_req = 1'b0;
        tick(); tick(); #1;
        checks++; if (u_if.wb_ready !== 1'b1) begin errors++; $display("FAIL rst_wb_ready: got %b exp 1", u_if.wb_ready); end
        checks++; if (u_if.lk_hit !== 1'b0) begin errors++; $display("FAIL rst_lk_hit: got %b exp 0", u_if.lk_hit); end
        checks++; if (u_if.lk_data !== 128'h0) begin errors++; $display("FAIL rst_lk_data: got %h exp 0", u_if.lk_data); end
        checks++; if (u_if.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", u_if.mem_req); end
        checks++; if (u_if.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", u_if.mem_addr); end
        checks++; if (u_if.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h exp 0", u_if.mem_wdata); end
        checks++; if (u_if.fl_complete !== 1'b0) begin errors++; $display("FAIL rst_fl_complete: got %b exp 0", u_if.fl_complete); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_line();
        logic [127:0] d;
        d = 128'h000000D3_000000D2_000000D1_000000D0;
        u_if.mem_ack = 1'b1;
        u_if.wb_valid = 1'b1; u_if.wb_addr = 32'h0000_1000; u_if.wb_data = d;
        #1;
        checks++; if (u_if.wb_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", u_if.wb_ready); end
        tick();
        u_if.wb_valid = 1'b0; u_if.lk_addr = 32'h0000_100C;
        #1;
        checks++; if (u_if.lk_hit !== 1'b1) begin errors++; $display("FAIL single_lk_hit: got %b exp 1", u_if.lk_hit); end
        checks++; if (u_if.lk_data !== d) begin errors++; $display("FAIL single_lk_data: got %h exp %h", u_if.lk_data, d); end
        for (int b = 0; b < 4; b++) begin
            checks++; if (u_if.mem_req !== 1'b1) begin errors++; $display("FAIL single_req_b%0d: got %b exp 1", b, u_if.mem_req); end
            checks++; if (u_if.mem_addr !== 32'h1000 + 4*b) begin errors++; $display("FAIL single_addr_b%0d: got %h exp %h", b, u_if.mem_addr, 32'h1000 + 4*b); end
            checks++; if (u_if.mem_wdata !== 32'hD0 + b) begin errors++; $display("FAIL single_data_b%0d: got %h exp %h", b, u_if.mem_wdata, 32'hD0 + b); end
            tick(); #1;
        end
        checks++; if (u_if.mem_req !== 1'b0) begin errors++; $display("FAIL single_req_end: got %b exp 0", u_if.mem_req); end
        checks++; if (u_if.lk_hit !== 1'b0) begin errors++; $display("FAIL single_lk_end: got %b exp 0", u_if.lk_hit); end
        tick(); #1;
        checks++; if (u_if.mem_req !== 1'b0) begin errors++; $display("FAIL single_req_idle: got %b exp 0", u_if.mem_req); end
        u_if.mem_ack = 1'b0;
    endtask

    task automatic test_full();
        int beats;
        u_if.mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            u_if.wb_valid = 1'b1; u_if.wb_addr = 32'h3000 + 32'h10*k; u_if.wb_data = 128'(32'hC000 + k);
            #1;
            checks++; if (u_if.wb_ready !== 1'b1) begin errors++; $display("FAIL full_ready_k%0d: got %b exp 1", k, u_if.wb_ready); end
            tick();
        end
        u_if.wb_addr = 32'h3040; u_if.wb_data = 128'hBAD;
        #1;
        checks++; if (u_if.wb_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after4: got %b exp 0", u_if.wb_ready); end
        tick();
        u_if.lk_addr = 32'h3040;
        #1;
        checks++; if (u_if.wb_ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold: got %b exp 0", u_if.wb_ready); end
        checks++; if (u_if.lk_hit !== 1'b0) begin errors++; $display("FAIL full_fifth_lk: got %b exp 0", u_if.lk_hit); end
        u_if.lk_addr = 32'h3024;
        #1;
        checks++; if (u_if.lk_data !== 128'hC002) begin errors++; $display("FAIL full_lk_third: got %h exp C002", u_if.lk_data); end
        u_if.wb_valid = 1'b0; u_if.mem_ack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            checks++; if (u_if.mem_addr !== 32'h3000 + 4*b) begin errors++; $display("FAIL full_addr_b%0d: got %h exp %h", b, u_if.mem_addr, 32'h3000 + 4*b); end
            checks++; if (u_if.wb_ready !== 1'b0) begin errors++; $display("FAIL full_ready_b%0d: got %b exp 0", b, u_if.wb_ready); end
            tick(); #1;
        end
        u_if.mem_ack = 1'b0;
        #1;
        checks++; if (u_if.wb_ready !== 1'b1) begin errors++; $display("FAIL full_ready_freed: got %b exp 1", u_if.wb_ready); end
        checks++; if (u_if.mem_req !== 1'b0) begin errors++; $display("FAIL full_req_gap: got %b exp 0", u_if.mem_req); end
        u_if.mem_ack = 1'b1;
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (u_if.mem_req === 1'b1) beats++;
            tick();
        end
        checks++; if (beats !== 12) begin errors++; $display("FAIL full_drain_beats: got %0d exp 12", beats); end
        checks++; if (u_if.mem_req !== 1'b0) begin errors++; $display("FAIL full_req_end: got %b exp 0", u_if.mem_req); end
        u_if.mem_ack = 1'b0;
    endtask

    task automatic test_dup_lookup();
        logic [127:0] a;
        logic [127:0] bdat;
        logic [31:0]  cap_data [16];
        logic [31:0]  cap_addr [16];
        int n;
        a    = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        bdat = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
        u_if.mem_ack = 1'b0;
        u_if.wb_valid = 1'b1; u_if.wb_addr = 32'h2000; u_if.wb_data = a;
        tick();
        u_if.wb_data = bdat; u_if.lk_addr = 32'h2008;
        #1;
        checks++; if (u_if.lk_data !== a) begin errors++; $display("FAIL dup_lk_first: got %h exp %h", u_if.lk_data, a); end
        tick();
        u_if.wb_valid = 1'b0;
        #1;
        checks++; if (u_if.lk_hit !== 1'b1) begin errors++; $display("FAIL dup_lk_hit: got %b exp 1", u_if.lk_hit); end
        checks++; if (u_if.lk_data !== bdat) begin errors++; $display("FAIL dup_lk_newest: got %h exp %h", u_if.lk_data, bdat); end
        u_if.lk_addr = 32'h2010;
        #1;
        checks++; if (u_if.lk_hit !== 1'b0 || u_if.lk_data !== 128'h0) begin errors++; $display("FAIL dup_lk_miss: got %b/%h exp 0/0", u_if.lk_hit, u_if.lk_data); end
        u_if.lk_addr = 32'h2008; u_if.mem_ack = 1'b1;
        n = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (u_if.mem_req === 1'b1 && n < 16) begin
                cap_data[n] = u_if.mem_wdata; cap_addr[n] = u_if.mem_addr; n++;
            end
            tick();
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL dup_beats: got %0d exp 8", n); end
        checks++; if (cap_data[0] !== 32'hA0A0A0A0) begin errors++; $display("FAIL dup_first_line: got %h exp A0A0A0A0", cap_data[0]); end
        checks++; if (cap_data[4] !== 32'hB0B0B0B0 || cap_addr[4] !== 32'h2000) begin errors++; $display("FAIL dup_second_line: got %h@%h exp B0B0B0B0@2000", cap_data[4], cap_addr[4]); end
        #1;
        checks++; if (u_if.lk_hit !== 1'b0 || u_if.lk_data !== 128'h0) begin errors++; $display("FAIL dup_lk_drained: got %b/%h exp 0/0", u_if.lk_hit, u_if.lk_data); end
        u_if.mem_ack = 1'b0;
    endtask

    task automatic test_stall();
        u_if.mem_ack = 1'b0;
        u_if.wb_valid = 1'b1; u_if.wb_addr = 32'h4000; u_if.wb_data = 128'h00000043_00000042_00000041_00000040;
        tick();
        u_if.wb_valid = 1'b0;
        #1;
        checks++; if (u_if.mem_addr !== 32'h4000 || u_if.mem_wdata !== 32'h40) begin errors++; $display("FAIL stall_b0: got %h/%h exp 4000/40", u_if.mem_addr, u_if.mem_wdata); end
        u_if.mem_ack = 1'b1;
        tick();
        u_if.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (u_if.mem_req !== 1'b1 || u_if.mem_addr !== 32'h4004 || u_if.mem_wdata !== 32'h41) begin
                errors++; $display("FAIL stall_hold_%0d: got %b/%h/%h exp 1/4004/41", i, u_if.mem_req, u_if.mem_addr, u_if.mem_wdata); end
            tick();
        end
        u_if.mem_ack = 1'b1;
        tick(); #1;
        checks++; if (u_if.mem_addr !== 32'h4008 || u_if.mem_wdata !== 32'h42) begin errors++; $display("FAIL stall_b2: got %h/%h exp 4008/42", u_if.mem_addr, u_if.mem_wdata); end
        tick(); #1;
        checks++; if (u_if.mem_addr !== 32'h400C || u_if.mem_wdata !== 32'h43) begin errors++; $display("FAIL stall_b3: got %h/%h exp 400C/43", u_if.mem_addr, u_if.mem_wdata); end
        tick(); #1;
        checks++; if (u_if.mem_req !== 1'b0) begin errors++; $display("FAIL stall_end: got %b exp 0", u_if.mem_req); end
        u_if.mem_ack = 1'b0;
    endtask

    task automatic test_flush();
        int beats;
        int early;
        u_if.mem_ack = 1'b0;
        u_if.wb_valid = 1'b1; u_if.wb_addr = 32'h5000; u_if.wb_data = 128'h5;
        tick();
        u_if.wb_addr = 32'h5010; u_if.wb_data = 128'h6;
        tick();
        u_if.wb_valid = 1'b0; u_if.fl_req = 1'b1; u_if.mem_ack = 1'b1;
        beats = 0; early = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (u_if.fl_complete !== 1'b0) early++;
            if (u_if.mem_req === 1'b1) beats++;
            tick();
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL flush_early: got %0d high cycles exp 0", early); end
        checks++; if (beats !== 8) begin errors++; $display("FAIL flush_beats: got %0d exp 8", beats); end
        #1;
        checks++; if (u_if.fl_complete !== 1'b1) begin errors++; $display("FAIL flush_rise: got %b exp 1", u_if.fl_complete); end
        u_if.fl_req = 1'b0;
        tick(); #1;
        checks++; if (u_if.fl_complete !== 1'b0) begin errors++; $display("FAIL flush_fall: got %b exp 0", u_if.fl_complete); end
        u_if.mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int beats;
        u_if.mem_ack = 1'b1;
        u_if.wb_valid = 1'b1; u_if.wb_addr = 32'h6000; u_if.wb_data = 128'h00000063_00000062_00000061_00000060;
        tick();
        u_if.wb_addr = 32'h6010; u_if.wb_data = 128'h77;
        tick();
        u_if.wb_valid = 1'b0;
        tick(); #1;
        checks++; if (u_if.mem_addr !== 32'h6008 || u_if.mem_wdata !== 32'h62) begin errors++; $display("FAIL rmid_b2: got %h/%h exp 6008/62", u_if.mem_addr, u_if.mem_wdata); end
        rst = 1'b0;
        #1;
        checks++; if (u_if.mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req_async: got %b exp 0", u_if.mem_req); end
        tick();
        rst = 1'b1;
        u_if.lk_addr = 32'h6010;
        #1;
        checks++; if (u_if.wb_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b exp 1", u_if.wb_ready); end
        checks++; if (u_if.lk_hit !== 1'b0) begin errors++; $display("FAIL rmid_lk_pending: got %b exp 0", u_if.lk_hit); end
        u_if.lk_addr = 32'h6000;
        #1;
        checks++; if (u_if.lk_hit !== 1'b0) begin errors++; $display("FAIL rmid_lk_head: got %b exp 0", u_if.lk_hit); end
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (u_if.mem_req !== 1'b0) beats++;
            tick();
        end
        checks++; if (beats !== 0) begin errors++; $display("FAIL rmid_no_beats: got %0d exp 0", beats); end
        u_if.mem_ack = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_line();
        test_full();
        test_dup_lookup();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
